// File: rtl/i2c_poll_pkg.sv
// Shared definitions for the i2c sensor polling sequencer: FSM encoding,
// timer width and the default board sensor address map.
package i2c_poll_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_ACC  = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_LATCH     = 3'd4,
      ST_GAP       = 3'd5
   } poll_state_e;

   localparam int TMR_W = 32;

   localparam logic [6:0] TEMP_ADDR0  = 7'h48;
   localparam logic [6:0] TEMP_ADDR1  = 7'h49;
   localparam logic [6:0] TEMP_ADDR2  = 7'h4A;
   localparam logic [6:0] TEMP_ADDR3  = 7'h4B;
   localparam logic [6:0] LIGHT_ADDR0 = 7'h44;
   localparam logic [6:0] LIGHT_ADDR1 = 7'h45;
   localparam logic [6:0] LIGHT_ADDR2 = 7'h46;
   localparam logic [6:0] LIGHT_ADDR3 = 7'h47;

   // channel 0 sits in the low bits: four temperature sensors, then four light sensors
   localparam logic [55:0] DEFAULT_ADDR_TABLE = {LIGHT_ADDR3, LIGHT_ADDR2, LIGHT_ADDR1, LIGHT_ADDR0,
                                                 TEMP_ADDR3, TEMP_ADDR2, TEMP_ADDR1, TEMP_ADDR0};

   // a phase of N cycles is a down-count from N-1 to 0; zero still costs one cycle
   function automatic logic [TMR_W-1:0] cyc_to_load(input int cyc);
      if (cyc <= 0) begin
         return {TMR_W{1'b0}};
      end else begin
         return TMR_W'(cyc - 1);
      end
   endfunction

endpackage

// File: rtl/poll_timer.sv
// Down-counter shared by the inter-sweep gap and the per-transaction timeout.
module poll_timer
   import i2c_poll_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             count,
   input  logic [TMR_W-1:0] load_val,
   output logic             expire
);

   localparam logic [TMR_W-1:0] ONE = {{(TMR_W-1){1'b0}}, 1'b1};

   logic [TMR_W-1:0] cnt_r;

   // load has priority; the count parks at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {TMR_W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (count && (cnt_r != {TMR_W{1'b0}})) begin
         cnt_r <= cnt_r - ONE;
      end
   end

   assign expire = (cnt_r == {TMR_W{1'b0}});

endmodule

// File: rtl/i2c_poll_seq.sv
// Round-robin sensor poller in front of a shared i2c master.
// Optional per-transaction timeout is built when I2C_POLL_TIMEOUT_EN is defined.
module i2c_poll_seq
   import i2c_poll_pkg::*;
#(
   parameter int NUM_CH      = 8,
   parameter int DATA_W      = 16,
   parameter int GAP_CYC     = 1000,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [NUM_CH*7-1:0]      addr_table,
   output logic                     m_start,
   output logic [6:0]               m_addr,
   output logic                     m_rw,
   output logic                     m_two_bytes,
   input  logic                     m_ready,
   input  logic [DATA_W-1:0]        m_read_data,
   input  logic                     m_ack_err,
   output logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [NUM_CH-1:0]        ch_valid,
   output logic [NUM_CH-1:0]        ch_err,
   output logic                     sweep_done,
   output logic                     busy
);

   localparam int               IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [TMR_W-1:0] GAP_LOAD = cyc_to_load(GAP_CYC);

   poll_state_e             state_r, state_s;
   logic [IDX_W-1:0]        ch_idx_r, ch_idx_s;
   logic                    end_s, timeout_s;
   logic                    tmr_load_s, tmr_count_s, tmr_expire_s;
   logic [TMR_W-1:0]        tmr_val_s;
   logic                    m_start_r, m_rw_r, m_two_bytes_r, sweep_done_r, busy_r;
   logic [6:0]              m_addr_r;
   logic [NUM_CH*DATA_W-1:0] ch_data_r;
   logic [NUM_CH-1:0]       ch_valid_r, ch_err_r;

`ifdef I2C_POLL_TIMEOUT_EN
   localparam logic [TMR_W-1:0] TO_LOAD = cyc_to_load(TIMEOUT_CYC);
   assign timeout_s   = ((state_r == ST_WAIT_ACC) || (state_r == ST_WAIT_DONE)) && tmr_expire_s;
   assign tmr_load_s  = (state_s == ST_ISSUE) || ((state_s == ST_GAP) && (state_r != ST_GAP));
   assign tmr_val_s   = (state_s == ST_GAP) ? GAP_LOAD : TO_LOAD;
   assign tmr_count_s = (state_r == ST_WAIT_ACC) || (state_r == ST_WAIT_DONE) || (state_r == ST_GAP);
`else
   assign timeout_s   = 1'b0;
   assign tmr_load_s  = (state_s == ST_GAP) && (state_r != ST_GAP);
   assign tmr_val_s   = GAP_LOAD;
   assign tmr_count_s = (state_r == ST_GAP);
`endif

   poll_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load_s),
      .count    (tmr_count_s),
      .load_val (tmr_val_s),
      .expire   (tmr_expire_s)
   );

   // state and channel index register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         ch_idx_r <= {IDX_W{1'b0}};
      end else begin
         state_r  <= state_s;
         ch_idx_r <= ch_idx_s;
      end
   end

   // next state; a latch or a timeout both end the transaction the same way
   always_comb begin
      state_s  = state_r;
      ch_idx_s = ch_idx_r;
      end_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            ch_idx_s = {IDX_W{1'b0}};
            if (enable && m_ready) begin
               state_s = ST_ISSUE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE:     state_s = ST_WAIT_ACC;
         ST_WAIT_ACC: begin
            if (timeout_s) begin
               end_s = 1'b1;
            end else if (!m_ready) begin
               state_s = ST_WAIT_DONE;
            end else begin
               state_s = ST_WAIT_ACC;
            end
         end
         ST_WAIT_DONE: begin
            if (timeout_s) begin
               end_s = 1'b1;
            end else if (m_ready) begin
               state_s = ST_LATCH;
            end else begin
               state_s = ST_WAIT_DONE;
            end
         end
         ST_LATCH:     end_s = 1'b1;
         ST_GAP: begin
            if (tmr_expire_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_GAP;
            end
         end
         default: begin
            state_s  = ST_IDLE;
            ch_idx_s = {IDX_W{1'b0}};
         end
      endcase
      // a finished last channel always closes the sweep, even if enable dropped
      if (end_s) begin
         if (ch_idx_r == LAST_IDX) begin
            state_s  = ST_GAP;
            ch_idx_s = {IDX_W{1'b0}};
         end else if (enable) begin
            state_s  = ST_ISSUE;
            ch_idx_s = ch_idx_r + IDX_ONE;
         end else begin
            state_s  = ST_IDLE;
            ch_idx_s = {IDX_W{1'b0}};
         end
      end else begin
         ch_idx_s = ch_idx_s;
      end
   end

   // per-channel result store; a NACK or timeout keeps the last good data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_data_r  <= {(NUM_CH*DATA_W){1'b0}};
         ch_valid_r <= {NUM_CH{1'b0}};
         ch_err_r   <= {NUM_CH{1'b0}};
      end else if (state_r == ST_LATCH) begin
         if (m_ack_err) begin
            ch_err_r[ch_idx_r] <= 1'b1;
         end else begin
            ch_data_r[ch_idx_r*DATA_W +: DATA_W] <= m_read_data;
            ch_valid_r[ch_idx_r]                 <= 1'b1;
            ch_err_r[ch_idx_r]                   <= 1'b0;
         end
      end else if (timeout_s) begin
         ch_err_r[ch_idx_r] <= 1'b1;
      end
   end

   // master handshake and status, registered from the next-state decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_start_r     <= 1'b0;
         m_rw_r        <= 1'b0;
         m_two_bytes_r <= 1'b0;
         m_addr_r      <= 7'd0;
         sweep_done_r  <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         m_start_r     <= (state_s == ST_ISSUE);
         m_rw_r        <= (state_s == ST_ISSUE);
         m_two_bytes_r <= (DATA_W == 16);
         sweep_done_r  <= (state_s == ST_GAP) && (state_r != ST_GAP);
         busy_r        <= (state_s != ST_IDLE);
         if (state_s == ST_ISSUE) begin
            m_addr_r <= addr_table[ch_idx_s*7 +: 7];
         end
      end
   end

   assign m_start     = m_start_r;
   assign m_rw        = m_rw_r;
   assign m_two_bytes = m_two_bytes_r;
   assign m_addr      = m_addr_r;
   assign sweep_done  = sweep_done_r;
   assign busy        = busy_r;
   assign ch_data     = ch_data_r;
   assign ch_valid    = ch_valid_r;
   assign ch_err      = ch_err_r;

endmodule
